// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and pipeline-register layouts for the memory stage.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mips_pkg;

   // Access size encodings used by MemRead/MemWrite.
   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_BYTE = 2'b01;
   localparam logic [1:0] MEM_HALF = 2'b10;
   localparam logic [1:0] MEM_WORD = 2'b11;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

   // EX/MEM pipeline register. killed marks an instruction flushed while its
   // access was already in flight: the access finishes but writeback is dropped.
   typedef struct packed {
      logic        vld;
      logic        killed;
      logic        branch;
      logic        memtoreg;
      logic        regwrite;
      logic        zero;
      logic        overflow;
      logic [1:0]  memread;
      logic [1:0]  memwrite;
      logic [31:0] aluout;
      logic [31:0] busb;
      logic [4:0]  rd;
   } ex_mem_t;

   // MEM/WB pipeline register, fault flags travel with the entry.
   typedef struct packed {
      logic        vld;
      logic        memtoreg;
      logic        regwrite;
      logic        branch_taken;
      logic        adel;
      logic        ades;
      logic        buserr;
      logic        ovf;
      logic [4:0]  rd;
      logic [31:0] aluout;
      logic [31:0] memdata;
      logic [31:0] badvaddr;
   } mem_wb_t;

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: little-endian byte-lane steering, byte enables, load extract and misalignment detect.
// Latency: purely combinational.
// Backpressure: none.
// Ports: addr_lo (low address bits), mem_read/mem_write (size codes), store_data, rdata in;
//        is_load, is_store, misaligned, be, wdata, load_data out.
module mem_align
   import mips_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  mem_read,
   input  logic [1:0]  mem_write,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic        is_load,
   output logic        is_store,
   output logic        misaligned,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [1:0]  size;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      // A nonzero MemRead wins; MemWrite is ignored for that instruction.
      is_load    = (mem_read != MEM_NONE);
      is_store   = !is_load && (mem_write != MEM_NONE);
      size       = is_load ? mem_read : mem_write;
      misaligned = 1'b0;
      be         = 4'b0000;
      wdata      = 32'h0;
      case (size)
         MEM_BYTE: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         MEM_HALF: begin
            misaligned = addr_lo[0];
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{store_data[15:0]}};
         end
         MEM_WORD: begin
            misaligned = (addr_lo != 2'b00);
            be         = 4'b1111;
            wdata      = store_data;
         end
         default: ;
      endcase
      // Loads only steer lanes; keep the write bus quiet.
      if (!is_store) begin
         wdata = 32'h0;
      end
   end

   always_comb begin
      ld_byte = 8'h0;
      case (addr_lo)
         2'd0:    ld_byte = rdata[7:0];
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         default: ld_byte = rdata[31:24];
      endcase
      ld_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      load_data = 32'h0;
      case (size)
         MEM_BYTE: load_data = sext8(ld_byte);
         MEM_HALF: load_data = sext16(ld_half);
         MEM_WORD: load_data = rdata;
         default:  load_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, single-outstanding data-memory port, MEM/WB register.
// Latency: 1 cycle EX/MEM -> MEM/WB, plus one cycle per dm_ready wait cycle.
// Backpressure: stall_out holds execute and EX/MEM while a request waits; TIMEOUT waits -> bus error.
// Ports: clk, reset (async active-low); execute-side *_in and mem_flush; stall_out to execute;
//        dm_* request/ready memory port; MEM/WB outputs *_out with one-cycle fault flags and badvaddr_out.
module mem_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_flush,
   input  logic        Branch_in,
   input  logic        MemtoReg_in,
   input  logic        RegWrite_in,
   input  logic        zero_in,
   input  logic        overflow_in,
   input  logic [1:0]  MemRead_in,
   input  logic [1:0]  MemWrite_in,
   input  logic [31:0] Aluout_in,
   input  logic [31:0] busB_in,
   input  logic [4:0]  rd_in,
   output logic        stall_out,
   output logic        dm_req,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ready,
   input  logic [31:0] dm_rdata,
   output logic        valid_out,
   output logic        MemtoReg_out,
   output logic        RegWrite_out,
   output logic [4:0]  rd_out,
   output logic [31:0] Aluout_out,
   output logic [31:0] memdata_out,
   output logic        branch_taken_out,
   output logic        adel_out,
   output logic        ades_out,
   output logic        buserr_out,
   output logic        ovf_out,
   output logic [31:0] badvaddr_out
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // The cycle whose wait count reaches TIMEOUT gives up instead of stalling.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   ex_mem_t       ex_q, ex_d;
   mem_wb_t       wb_q, wb_d;
   mem_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic        is_load, is_store, misaligned;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, load_data;
   logic        ovf_kill, mem_op, mem_go, timeout, adel, ades;

   mem_align u_align (
      .addr_lo    (ex_q.aluout[1:0]),
      .mem_read   (ex_q.memread),
      .mem_write  (ex_q.memwrite),
      .store_data (ex_q.busb),
      .rdata      (dm_rdata),
      .is_load    (is_load),
      .is_store   (is_store),
      .misaligned (misaligned),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (load_data)
   );

   // Arithmetic overflow on a writing instruction cancels both writeback and memory op.
   assign ovf_kill = ex_q.vld & ex_q.overflow & ex_q.regwrite;
   assign mem_op   = ex_q.vld & (is_load | is_store) & ~ovf_kill;
   assign mem_go   = mem_op & ~misaligned;
   assign adel     = mem_op & misaligned & is_load;
   assign ades     = mem_op & misaligned & is_store;

   // Request is a pure function of the held EX/MEM entry, so the address, lanes
   // and data stay constant for as long as the request is outstanding.
   assign dm_req   = mem_go;
   assign dm_we    = mem_go & is_store;
   assign dm_be    = mem_go ? lane_be    : 4'b0000;
   assign dm_addr  = mem_go ? ex_q.aluout : 32'h0;
   assign dm_wdata = mem_go ? lane_wdata : 32'h0;

   assign stall_out = mem_go & ~dm_ready & ~timeout;

   // Access FSM: only counts wait cycles; the request itself comes from EX/MEM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_go && !dm_ready) begin
               state_d = ACCESS;
               cnt_d   = CW'(1);
            end
         end
         ACCESS: begin
            if (dm_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               timeout = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // EX/MEM next value. A flush during a stall cannot cancel the access already
   // on the bus (stores are not cancellable), so it only marks the entry killed.
   always_comb begin
      ex_d = ex_q;
      if (!stall_out) begin
         if (mem_flush) begin
            ex_d = '0;
         end else begin
            ex_d.vld      = 1'b1;
            ex_d.killed   = 1'b0;
            ex_d.branch   = Branch_in;
            ex_d.memtoreg = MemtoReg_in;
            ex_d.regwrite = RegWrite_in;
            ex_d.zero     = zero_in;
            ex_d.overflow = overflow_in;
            ex_d.memread  = MemRead_in;
            ex_d.memwrite = MemWrite_in;
            ex_d.aluout   = Aluout_in;
            ex_d.busb     = busB_in;
            ex_d.rd       = rd_in;
         end
      end else if (mem_flush) begin
         ex_d.killed = 1'b1;
      end
   end

   // MEM/WB next value: a bubble while stalled, otherwise the finished entry.
   always_comb begin
      wb_d = '0;
      if (!stall_out) begin
         wb_d.vld          = ex_q.vld;
         wb_d.memtoreg     = ex_q.memtoreg;
         wb_d.regwrite     = ex_q.regwrite & ~(adel | ades | timeout | ovf_kill | ex_q.killed);
         wb_d.branch_taken = ex_q.branch & ex_q.zero & ~ex_q.killed;
         wb_d.adel         = adel;
         wb_d.ades         = ades;
         wb_d.buserr       = timeout;
         wb_d.ovf          = ovf_kill;
         wb_d.rd           = ex_q.rd;
         wb_d.aluout       = ex_q.aluout;
         wb_d.memdata      = (mem_go & is_load & dm_ready) ? load_data : 32'h0;
         wb_d.badvaddr     = (adel | ades | timeout) ? ex_q.aluout : 32'h0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q <= '0;
         wb_q <= '0;
      end else begin
         ex_q <= ex_d;
         wb_q <= wb_d;
      end
   end

   assign valid_out        = wb_q.vld;
   assign MemtoReg_out     = wb_q.memtoreg;
   assign RegWrite_out     = wb_q.regwrite;
   assign rd_out           = wb_q.rd;
   assign Aluout_out       = wb_q.aluout;
   assign memdata_out      = wb_q.memdata;
   assign branch_taken_out = wb_q.branch_taken;
   assign adel_out         = wb_q.adel;
   assign ades_out         = wb_q.ades;
   assign buserr_out       = wb_q.buserr;
   assign ovf_out          = wb_q.ovf;
   assign badvaddr_out     = wb_q.badvaddr;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed stimulus against a transaction-level model of mem_stage.
// Latency: n/a (testbench).
// Backpressure: bench plays the data memory and chooses the wait count of every access.
module tb_mem_stage;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset, mem_flush;
   logic        Branch_in, MemtoReg_in, RegWrite_in, zero_in, overflow_in;
   logic [1:0]  MemRead_in, MemWrite_in;
   logic [31:0] Aluout_in, busB_in;
   logic [4:0]  rd_in;
   logic        stall_out, dm_req, dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ready;
   logic [31:0] dm_rdata;
   logic        valid_out, MemtoReg_out, RegWrite_out;
   logic [4:0]  rd_out;
   logic [31:0] Aluout_out, memdata_out;
   logic        branch_taken_out, adel_out, ades_out, buserr_out, ovf_out;
   logic [31:0] badvaddr_out;

   mem_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .mem_flush(mem_flush),
      .Branch_in(Branch_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
      .zero_in(zero_in), .overflow_in(overflow_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .Aluout_in(Aluout_in), .busB_in(busB_in), .rd_in(rd_in),
      .stall_out(stall_out), .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
      .valid_out(valid_out), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
      .rd_out(rd_out), .Aluout_out(Aluout_out), .memdata_out(memdata_out),
      .branch_taken_out(branch_taken_out), .adel_out(adel_out), .ades_out(ades_out),
      .buserr_out(buserr_out), .ovf_out(ovf_out), .badvaddr_out(badvaddr_out)
   );

   always #5 clk = ~clk;

   // One instruction as the model sees it: w = wait cycles the memory will insert
   // (>= TIMEOUT means never ready), k = cycles it has spent in the memory stage.
   typedef struct {
      bit vld, killed, branch, memtoreg, regwrite, zero, overflow;
      bit [1:0] mr, mw;
      bit [31:0] alu, b;
      bit [4:0] rd;
      int w;
      int k;
   } instr_t;

   typedef struct {
      bit vld, m2r, rw, br, adel, ades, berr, ovf;
      bit [4:0] rd;
      bit [31:0] alu, md, badv;
   } wb_t;

   instr_t cur, nxt_g;
   bit     flush_g;
   wb_t    wb_exp;
   int     n_vec, n_bad, stall_seen, store_done;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int sz(instr_t i);
      return (i.mr != 0) ? int'(i.mr) : int'(i.mw);
   endfunction
   function automatic bit ld(instr_t i);    return i.mr != 0; endfunction
   function automatic bit st(instr_t i);    return (i.mr == 0) && (i.mw != 0); endfunction
   function automatic bit ovf(instr_t i);   return i.vld && i.overflow && i.regwrite; endfunction
   function automatic bit memop(instr_t i); return i.vld && (ld(i) || st(i)) && !ovf(i); endfunction
   function automatic bit mis(instr_t i);
      int off = int'(i.alu % 4);
      return (sz(i) == 2 && (off % 2) != 0) || (sz(i) == 3 && off != 0);
   endfunction
   function automatic bit access(instr_t i); return memop(i) && !mis(i); endfunction
   function automatic bit tmo(instr_t i);    return access(i) && i.w >= TIMEOUT; endfunction
   function automatic bit stall(instr_t i);
      int last = tmo(i) ? TIMEOUT - 1 : i.w;
      return access(i) && i.k < last;
   endfunction

   function automatic logic [3:0] exp_be(instr_t i);
      int off = int'(i.alu % 4);
      case (sz(i))
         1:       return 4'(1 << off);
         2:       return (off >= 2) ? 4'hC : 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] exp_wd(instr_t i);
      case (sz(i))
         1:       return (i.b & 32'hFF) * 32'h0101_0101;
         2:       return (i.b & 32'hFFFF) * 32'h0001_0001;
         default: return i.b;
      endcase
   endfunction

   function automatic logic [31:0] ld_val(instr_t i, logic [31:0] rdata);
      int off = int'(i.alu % 4);
      logic [31:0] v;
      case (sz(i))
         1: begin
            v = (rdata >> (8 * off)) & 32'hFF;
            if (v >= 128) v = v - 256;
         end
         2: begin
            v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
            if (v >= 32768) v = v - 65536;
         end
         default: v = rdata;
      endcase
      return v;
   endfunction

   function automatic wb_t result(instr_t i, logic [31:0] rdata);
      wb_t r = '{default: 0};
      bit  o = ovf(i);
      bit  m = memop(i) && mis(i);
      bit  t = tmo(i);
      r.vld  = i.vld;
      r.m2r  = i.memtoreg;
      r.rd   = i.rd;
      r.alu  = i.alu;
      r.adel = m && ld(i);
      r.ades = m && st(i);
      r.berr = t;
      r.ovf  = o;
      r.rw   = i.regwrite && !m && !t && !o && !i.killed;
      r.br   = i.branch && i.zero && !i.killed;
      r.md   = (access(i) && ld(i) && !t) ? ld_val(i, rdata) : 32'h0;
      r.badv = (m || t) ? i.alu : 32'h0;
      return r;
   endfunction

   function automatic instr_t mk(bit [1:0] mr, bit [1:0] mw, bit [31:0] alu, bit [31:0] b, bit rw, int w);
      instr_t i = '{default: 0};
      i.vld = 1; i.mr = mr; i.mw = mw; i.alu = alu; i.b = b; i.regwrite = rw; i.w = w;
      i.rd = 5'd9; i.memtoreg = (mr != 0);
      return i;
   endfunction

   function automatic instr_t rnd();
      instr_t i = '{default: 0};
      int r;
      i.vld      = 1;
      i.branch   = 1'($urandom_range(0, 1));
      i.zero     = 1'($urandom_range(0, 1));
      i.memtoreg = 1'($urandom_range(0, 1));
      i.regwrite = 1'($urandom_range(0, 1));
      i.overflow = ($urandom_range(0, 9) == 0);
      i.mr       = ($urandom_range(0, 99) < 40) ? 2'($urandom_range(1, 3)) : 2'b00;
      i.mw       = 2'($urandom_range(0, 3));
      i.alu      = $urandom;
      i.b        = $urandom;
      i.rd       = 5'($urandom);
      r          = int'($urandom_range(0, 99));
      i.w        = (r < 45) ? 0 : (r < 85) ? int'($urandom_range(1, 4)) : (r < 92) ? TIMEOUT - 1 : TIMEOUT + 5;
      return i;
   endfunction

   // ---------------- per-cycle drive / compare / advance ----------------
   task automatic check_cycle();
      bit acc = access(cur);
      chk1("stall_out", stall_out, stall(cur));
      chk1("dm_req", dm_req, acc);
      if (acc) begin
         chk1("dm_we", dm_we, st(cur));
         chk32("dm_be", 32'(dm_be), 32'(exp_be(cur)));
         chk32("dm_addr", dm_addr, cur.alu);
         if (st(cur)) chk32("dm_wdata", dm_wdata, exp_wd(cur));
      end
      if (dm_req && dm_ready && dm_we) store_done++;
      if (stall_out) stall_seen++;
      chk1("valid_out", valid_out, wb_exp.vld);
      chk1("MemtoReg_out", MemtoReg_out, wb_exp.m2r);
      chk1("RegWrite_out", RegWrite_out, wb_exp.rw);
      chk32("rd_out", 32'(rd_out), 32'(wb_exp.rd));
      chk32("Aluout_out", Aluout_out, wb_exp.alu);
      chk32("memdata_out", memdata_out, wb_exp.md);
      chk1("branch_taken_out", branch_taken_out, wb_exp.br);
      chk1("adel_out", adel_out, wb_exp.adel);
      chk1("ades_out", ades_out, wb_exp.ades);
      chk1("buserr_out", buserr_out, wb_exp.berr);
      chk1("ovf_out", ovf_out, wb_exp.ovf);
      chk32("badvaddr_out", badvaddr_out, wb_exp.badv);
   endtask

   // Called just after a rising edge: drive this cycle's inputs, then compare at the falling edge.
   task automatic begin_cycle(input instr_t nxt, input bit flush, input logic [31:0] rdata);
      nxt_g       = nxt;
      flush_g     = flush;
      Branch_in   = nxt.branch;   MemtoReg_in = nxt.memtoreg; RegWrite_in = nxt.regwrite;
      zero_in     = nxt.zero;     overflow_in = nxt.overflow;
      MemRead_in  = nxt.mr;       MemWrite_in = nxt.mw;
      Aluout_in   = nxt.alu;      busB_in     = nxt.b;        rd_in       = nxt.rd;
      mem_flush   = flush;
      dm_rdata    = rdata;
      if (access(cur)) dm_ready = (cur.w < TIMEOUT) && (cur.k == cur.w);
      else             dm_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_cycle();
   endtask

   task automatic end_cycle();
      if (!stall(cur)) begin
         wb_exp = result(cur, dm_rdata);
         if (flush_g) cur = '{default: 0};
         else begin
            cur        = nxt_g;
            cur.vld    = 1;
            cur.killed = 0;
            cur.k      = 0;
         end
      end else begin
         wb_exp = '{default: 0};
         cur.k++;
         if (flush_g) cur.killed = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk1({tag, " stall_out"}, stall_out, 1'b0);
      chk1({tag, " dm_req"}, dm_req, 1'b0);
      chk1({tag, " dm_we"}, dm_we, 1'b0);
      chk32({tag, " dm_be"}, 32'(dm_be), 32'h0);
      chk32({tag, " dm_addr"}, dm_addr, 32'h0);
      chk32({tag, " dm_wdata"}, dm_wdata, 32'h0);
      chk1({tag, " valid_out"}, valid_out, 1'b0);
      chk1({tag, " MemtoReg_out"}, MemtoReg_out, 1'b0);
      chk1({tag, " RegWrite_out"}, RegWrite_out, 1'b0);
      chk32({tag, " rd_out"}, 32'(rd_out), 32'h0);
      chk32({tag, " Aluout_out"}, Aluout_out, 32'h0);
      chk32({tag, " memdata_out"}, memdata_out, 32'h0);
      chk1({tag, " branch_taken_out"}, branch_taken_out, 1'b0);
      chk1({tag, " adel_out"}, adel_out, 1'b0);
      chk1({tag, " ades_out"}, ades_out, 1'b0);
      chk1({tag, " buserr_out"}, buserr_out, 1'b0);
      chk1({tag, " ovf_out"}, ovf_out, 1'b0);
      chk32({tag, " badvaddr_out"}, badvaddr_out, 32'h0);
   endtask

   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t nop;
      n_vec = 0; n_bad = 0; stall_seen = 0; store_done = 0;
      cur = '{default: 0}; wb_exp = '{default: 0};
      nop = mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 0);
      reset = 1'b0; mem_flush = 1'b0;
      Branch_in = 0; MemtoReg_in = 0; RegWrite_in = 0; zero_in = 0; overflow_in = 0;
      MemRead_in = 0; MemWrite_in = 0; Aluout_in = 0; busB_in = 0; rd_in = 0;
      dm_ready = 1'b0; dm_rdata = 32'h0;
      #12;
      all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      // sw 0x100, zero-wait
      begin_cycle(mk(2'b00, 2'b11, 32'h100, 32'hDEADBEEF, 1'b0, 0), 1'b0, 32'h0); end_cycle();
      begin_cycle(nop, 1'b0, 32'h0);
      chk1("sw dm_req", dm_req, 1'b1);
      chk1("sw dm_we", dm_we, 1'b1);
      chk32("sw dm_be", 32'(dm_be), 32'hF);
      chk32("sw dm_wdata", dm_wdata, 32'hDEADBEEF);
      chk1("sw no stall", stall_out, 1'b0);
      end_cycle();

      // lb 0x103, three wait cycles
      begin_cycle(mk(2'b01, 2'b00, 32'h103, 32'h0, 1'b1, 3), 1'b0, 32'h0); end_cycle();
      stall_seen = 0;
      repeat (4) begin begin_cycle(nop, 1'b0, 32'h80FF_0000); end_cycle(); end
      chk32("lb stall cycles", 32'(stall_seen), 32'd3);
      begin_cycle(nop, 1'b0, 32'h0);
      chk32("lb memdata_out", memdata_out, 32'hFFFF_FF80);
      chk1("lb RegWrite_out", RegWrite_out, 1'b1);
      end_cycle();

      // sh 0x102 lane steering, then misaligned lh 0x101
      begin_cycle(mk(2'b00, 2'b10, 32'h102, 32'h1234ABCD, 1'b0, 0), 1'b0, 32'h0); end_cycle();
      begin_cycle(nop, 1'b0, 32'h0);
      chk32("sh dm_be", 32'(dm_be), 32'hC);
      chk32("sh dm_wdata", dm_wdata, 32'hABCDABCD);
      end_cycle();
      begin_cycle(mk(2'b10, 2'b00, 32'h101, 32'h0, 1'b1, 0), 1'b0, 32'h0); end_cycle();
      begin_cycle(nop, 1'b0, 32'h0);
      chk1("lh misaligned dm_req", dm_req, 1'b0);
      end_cycle();
      begin_cycle(nop, 1'b0, 32'h0);
      chk1("lh adel_out", adel_out, 1'b1);
      chk32("lh badvaddr_out", badvaddr_out, 32'h101);
      chk1("lh RegWrite_out", RegWrite_out, 1'b0);
      end_cycle();

      // lw that never gets dm_ready
      begin_cycle(mk(2'b11, 2'b00, 32'h300, 32'h0, 1'b1, TIMEOUT + 5), 1'b0, 32'h0); end_cycle();
      stall_seen = 0;
      repeat (TIMEOUT) begin begin_cycle(nop, 1'b0, 32'h0); end_cycle(); end
      chk32("timeout stall cycles", 32'(stall_seen), 32'd15);
      begin_cycle(nop, 1'b0, 32'h0);
      chk1("timeout buserr_out", buserr_out, 1'b1);
      chk1("timeout RegWrite_out", RegWrite_out, 1'b0);
      chk32("timeout badvaddr_out", badvaddr_out, 32'h300);
      chk1("resume stall_out", stall_out, 1'b0);
      end_cycle();

      // flush while a 2-wait store is on the bus
      begin_cycle(mk(2'b00, 2'b11, 32'h400, 32'h55AA55AA, 1'b1, 2), 1'b0, 32'h0); end_cycle();
      store_done = 0;
      begin_cycle(nop, 1'b1, 32'h0); end_cycle();
      repeat (2) begin begin_cycle(nop, 1'b0, 32'h0); end_cycle(); end
      begin_cycle(nop, 1'b0, 32'h0);
      chk32("flushed store count", 32'(store_done), 32'd1);
      chk1("flushed valid_out", valid_out, 1'b1);
      chk1("flushed RegWrite_out", RegWrite_out, 1'b0);
      end_cycle();

      // randomized traffic
      repeat (3000) begin
         begin_cycle(rnd(), $urandom_range(0, 99) < 8, $urandom);
         end_cycle();
      end

      // reset in the middle of a waiting access
      begin_cycle(mk(2'b11, 2'b00, 32'h200, 32'h0, 1'b1, TIMEOUT + 5), 1'b0, 32'h0); end_cycle();
      repeat (3) begin begin_cycle(nop, 1'b0, 32'h0); end_cycle(); end
      chk1("pre-reset dm_req", dm_req, 1'b1);
      #2 reset = 1'b0;
      #1 all_zero("mid-access reset");
      @(posedge clk); #1;
      reset = 1'b1;
      cur = '{default: 0};
      wb_exp = '{default: 0};
      repeat (20) begin
         begin_cycle(rnd(), 1'b0, $urandom);
         end_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipelined CPU, directly downstream of the execute stage. Holds the EX/MEM pipeline register, drives a single-outstanding request/ready data-memory port with byte-lane steering and load sign-extension, and produces the MEM/WB pipeline register. Stalls upstream while an access waits, detects misaligned accesses and bus timeouts, and suppresses register writeback on faults, flush or arithmetic overflow.

## Interface
- TIMEOUT, 16: wait cycles without `dm_ready` before bus error (≥2).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- mem_flush  in  1  kill instruction in EX/MEM.
- Branch_in, MemtoReg_in, RegWrite_in, zero_in, overflow_in  in  1 each  control/flags from execute.
- MemRead_in, MemWrite_in  in  2 each  00 none, 01 byte, 10 half, 11 word.
- Aluout_in, busB_in  in  32 each  address/result, store data.
- rd_in  in  5  destination register.
- stall_out  out  1  hold execute stage and EX/MEM input.
- dm_req, dm_we  out  1 each  memory request, write enable.
- dm_be  out  4  byte enables; dm_addr, dm_wdata  out  32 each.
- dm_ready  in  1; dm_rdata  in  32.
- valid_out, MemtoReg_out, RegWrite_out  out  1 each  MEM/WB register.
- rd_out  out  5; Aluout_out, memdata_out  out  32 each.
- branch_taken_out  out  1  `Branch & zero`, registered.
- adel_out, ades_out, buserr_out, ovf_out  out  1 each  one-cycle fault flags with the MEM/WB entry.
- badvaddr_out  out  32  faulting address, else 0.

## Operation
- EX/MEM register loads all `*_in` on each edge when `stall_out`=0; holds otherwise. `mem_flush` (when not stalled) loads a bubble (all controls 0).
- MemRead nonzero takes priority; MemWrite ignored in that case.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0. Misaligned: no `dm_req`; adel (load) / ades (store), badvaddr=addr, RegWrite_out=0.
- Store steering (little-endian): byte → wdata={4{B[7:0]}}, be=0001<<addr[1:0]; half → {2{B[15:0]}}, be=addr[1]?1100:0011; word → B, 1111. Loads drive be the same way, dm_we=0.
- Load extract: byte = rdata>>(8·addr[1:0]) sign-extended from bit 7; half from bit 15 at addr[1]; word unmodified.
- overflow_in with RegWrite: RegWrite_out=0, ovf_out=1, memory op suppressed.
- FSM states IDLE, ACCESS. IDLE: valid aligned mem op → dm_req=1 combinationally; dm_ready=1 completes same cycle; else → ACCESS, counter=1. ACCESS: dm_req held; dm_ready → complete, IDLE; counter reaches TIMEOUT → buserr_out, badvaddr, RegWrite_out=0, IDLE.
- stall_out = dm_req & ~dm_ready & no timeout this cycle.
- mem_flush while stalled: access continues to completion (store not cancellable); its MEM/WB entry has RegWrite_out=0.

## Timing
- Non-memory op: 1 cycle EX/MEM → MEM/WB.
- Zero-wait memory: 1 cycle, no stall. N wait cycles: stall_out high N cycles.
- dm_addr/dm_we/dm_be/dm_wdata constant while dm_req high.
- During stall, MEM/WB loads a bubble (valid_out=0, RegWrite_out=0).
- Fault flags high exactly one cycle, aligned with valid_out.
- Reset: state IDLE, counter 0, both pipeline registers and every output 0 (dm_req=0, stall_out=0). Reset mid-ACCESS drops the request immediately.

## Structure
- Shared package `mips_pkg`: MEM_NONE/BYTE/HALF/WORD encodings, `mem_state_t` enum {IDLE, ACCESS}.
- Sub-module `mem_align` (combinational): store lane steering, byte enables, load extract/sign-extend, misalignment detect.

## Test plan
- sw addr 0x100, B=0xDEADBEEF, zero-wait → dm_be=1111, wdata=0xDEADBEEF, we=1, no stall.
- lb addr 0x103, rdata 0x80FF_0000, 3 wait cycles → stall_out 3 cycles, memdata_out=0xFFFFFF80.
- sh addr 0x102, B=0x1234ABCD → be=1100, wdata=0xABCDABCD; lh addr 0x101 → adel_out=1, badvaddr=0x101, no dm_req.
- lw, dm_ready never asserted, TIMEOUT=16 → stall 15 cycles, buserr_out=1, RegWrite_out=0, pipeline resumes.
- mem_flush during 2-cycle-wait sw → store completes once, RegWrite_out=0; reset asserted mid-ACCESS → dm_req=0, all outputs 0 asynchronously.
